mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
Multi-cycle controller for the M-extension unit in the EX stage. Accepts one MUL/DIV/REM operation from EX through a valid/ready handshake and runs an iterative radix-2 restoring divider or a single-pass multiply. Holds the result until EX consumes it. Drives o_busy into the pipeline stall logic, and i_flush aborts in-flight work on branch redirect or exception.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even, >= 8
CNT_WIDTH, $clog2(DATA_WIDTH), width of the divide iteration counter (derived, not overridden)

Ports:
i_clock  input  1  clock
i_reset  input  1  reset, synchronous, active-high
i_flush  input  1  abort current operation, return to IDLE
i_reqValid  input  1  EX presents an operation
o_reqReady  output  1  sequencer can accept an operation
i_reqOp  input  3  MduOp: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_reqA  input  DATA_WIDTH  operand A (rs1 value)
i_reqB  input  DATA_WIDTH  operand B (rs2 value)
o_rspValid  output  1  result available
i_rspReady  input  1  EX consumes result
o_result  output  DATA_WIDTH  result
o_busy  output  1  operation in progress; pipeline stall request

Behaviour:
- Interface decision: one clock (i_clock); reset i_reset is synchronous and active-high.
- States: IDLE, MUL, DIV, DONE. Reset puts the block in IDLE with o_rspValid=0, o_result=0, o_busy=0, counter=0. o_reqReady=1 from the first cycle after reset.
- o_reqReady = (state==IDLE) && !i_flush.
- Accept occurs when i_reqValid && o_reqReady. Op and operands are latched at accept; later changes on the inputs are ignored.
- o_busy = (state==MUL) || (state==DIV) || (state==DONE && !i_rspReady).
- Accept at cycle T, MUL/MULH/MULHSU/MULHU:
  - T+1 in MUL: full 2*DATA_WIDTH product registered.
  - Operands are sign/zero-extended to DATA_WIDTH+1 by op: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
  - MUL returns the low half; all others return the high half.
  - T+2 in DONE with o_rspValid=1.
- Accept at T, DIV/DIVU/REM/REMU, fast paths (go IDLE -> DONE directly, result valid at T+1):
  - B==0: quotient = all ones; remainder = A.
  - Signed op with A==most-negative and B==-1: quotient = A; remainder = 0.
- Accept at T, DIV/DIVU/REM/REMU, normal path:
  - Signed ops take magnitudes at accept.
  - DIV state runs exactly DATA_WIDTH iterations, T+1..T+DATA_WIDTH. Counter loads DATA_WIDTH-1 and decrements; at counter==0 the next state is DONE.
  - DONE at T+DATA_WIDTH+1.
  - Signed result fix-up happens on the DIV->DONE edge: quotient negated if sign(A)!=sign(B); remainder takes sign(A).
- DONE: o_rspValid=1 and o_result stable until i_rspReady=1. On that cycle the next state is IDLE. A new request cannot be accepted in the same cycle (single-issue, no bypass).
- i_flush in any state: next state IDLE, o_rspValid=0 next cycle, counter cleared, o_result holds its value (don't-care).
  - i_flush with i_reqValid in IDLE: request not accepted.
  - i_flush with i_rspReady in DONE: flush wins; the response counts as discarded.
- i_reset has priority over i_flush and all other inputs; reset mid-divide behaves identically to power-on reset.
- Arithmetic is modular DATA_WIDTH; no exceptions are signalled (RISC-V semantics).

Decomposition:
- The shared Types package gains MduOp (3-bit enum, order as listed) and MduState (IDLE, MUL, DIV, DONE).
- Helper functions isSignedOp() and isRemOp() go in the same package.
- One sub-module: mdu_divider_step. It is combinational: one restoring shift/subtract iteration on {remainder, quotient} against the divisor, parameterised by DATA_WIDTH. The sequencer instantiates it and registers its output each DIV cycle.

Test Plan:
- Reset with i_reqValid=1 -> o_reqReady=1 on the first post-reset cycle; o_rspValid=0, o_busy=0; no accept during the reset cycle.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF, accepted at T -> o_rspValid at T+2, o_result=0xFFFFFFFE. MUL on the same operands -> 0x00000001. MULHSU A=0xFFFFFFFF (-1), B=2 -> 0xFFFFFFFF.
- DIV A=-7 (0xFFFFFFF9), B=2 -> o_rspValid exactly at T+33, o_result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF. o_busy=1 from T+1 through T+32.
- DIVU A=5, B=0 -> o_result=0xFFFFFFFF at T+1. REM A=0x80000000, B=0xFFFFFFFF -> 0 at T+1. DIV on the same operands -> 0x80000000.
- Backpressure: hold i_rspReady=0 for 5 cycles in DONE -> o_result stable, o_busy=1, o_reqReady=0. Release -> IDLE next cycle, back-to-back request accepted that cycle.
- i_flush asserted at iteration 10 of DIVU -> IDLE next cycle, o_rspValid never rises. A new DIVU 100/7 then completes with 14, unaffected by the aborted state.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared types for the M-extension sequencer.
// Operation and state encodings plus small op-class helpers.
package mdu_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } MduOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } MduState;

    // Multiplies occupy the lower half of the encoding.
    function automatic logic isMulOp(MduOp op);
        return !op[2];
    endfunction

    // Signed divide/remainder: operands handled as two's complement.
    function automatic logic isSignedOp(MduOp op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic isRemOp(MduOp op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_divider_step.sv
// One restoring radix-2 divide iteration.
// Shifts {rem, quo} left by one and conditionally subtracts the divisor.
module mdu_divider_step
    import mdu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] remIn,
    input  logic [DATA_WIDTH-1:0] quoIn,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] remOut,
    output logic [DATA_WIDTH-1:0] quoOut
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    assign shifted = {remIn, quoIn[DATA_WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // Borrow out (diff MSB) means the trial subtract failed: restore.
    assign remOut = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0]
                                     : diff[DATA_WIDTH-1:0];
    assign quoOut = {quoIn[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV/REM controller for the EX stage.
// Single-pass multiply, iterative restoring divide, held result.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_reqValid,
    output logic                  o_reqReady,
    input  logic [2:0]            i_reqOp,
    input  logic [DATA_WIDTH-1:0] i_reqA,
    input  logic [DATA_WIDTH-1:0] i_reqB,
    output logic                  o_rspValid,
    input  logic                  i_rspReady,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_busy
);

    localparam int W = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    MduState state;
    MduState stateNext;
    MduOp    reqOp;
    MduOp    opReg;

    logic [W-1:0]         aReg;
    logic [W-1:0]         bReg;
    logic [W-1:0]         remReg;
    logic [W-1:0]         resultReg;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 negQ;
    logic                 negR;

    logic         accept;
    logic         reqSigned;
    logic         reqDivZero;
    logic         reqOverflow;
    logic         reqFast;
    logic [W-1:0] absA;
    logic [W-1:0] absB;
    logic [W-1:0] stepRem;
    logic [W-1:0] stepQuo;
    logic [W-1:0] fixQuo;
    logic [W-1:0] fixRem;
    logic         signA;
    logic         signB;
    logic [2*W-1:0] extA;
    logic [2*W-1:0] extB;
    logic [2*W-1:0] product;

    assign reqOp      = MduOp'(i_reqOp);
    assign o_reqReady = (state == IDLE) && !i_flush;
    assign accept     = i_reqValid && o_reqReady;
    assign o_rspValid = (state == DONE);
    assign o_busy     = (state == MUL) || (state == DIV) ||
                        ((state == DONE) && !i_rspReady);
    assign o_result   = resultReg;

    assign reqSigned   = isSignedOp(reqOp);
    assign reqDivZero  = (i_reqB == '0);
    assign reqOverflow = reqSigned && (i_reqA == MOST_NEG) &&
                         (i_reqB == '1);
    assign reqFast     = reqDivZero || reqOverflow;

    assign absA = (reqSigned && i_reqA[W-1]) ? -i_reqA : i_reqA;
    assign absB = (reqSigned && i_reqB[W-1]) ? -i_reqB : i_reqB;

    // Extending past W+1 bits is harmless: the product is taken mod 2^2W.
    assign signA   = (opReg == OP_MULH) || (opReg == OP_MULHSU);
    assign signB   = (opReg == OP_MULH);
    assign extA    = {{W{signA & aReg[W-1]}}, aReg};
    assign extB    = {{W{signB & bReg[W-1]}}, bReg};
    assign product = extA * extB;

    assign fixQuo = negQ ? -stepQuo : stepQuo;
    assign fixRem = negR ? -stepRem : stepRem;

    mdu_divider_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .remIn  (remReg),
        .quoIn  (aReg),
        .divisor(bReg),
        .remOut (stepRem),
        .quoOut (stepQuo)
    );

    // State register; reset outranks everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= stateNext;
    end

    // Next-state: flush always returns to IDLE.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (isMulOp(reqOp)) stateNext = MUL;
                    else if (reqFast)   stateNext = DONE;
                    else                stateNext = DIV;
                end
            end
            MUL:  stateNext = DONE;
            DIV:  if (cnt == '0) stateNext = DONE;
            DONE: if (i_rspReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (i_flush) stateNext = IDLE;
    end

    // Datapath: operand capture, multiply, divide iterations, fix-up.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            opReg     <= OP_MUL;
            aReg      <= '0;
            bReg      <= '0;
            remReg    <= '0;
            resultReg <= '0;
            cnt       <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
        end else if (i_flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg <= reqOp;
                        if (isMulOp(reqOp)) begin
                            aReg <= i_reqA;
                            bReg <= i_reqB;
                        end else if (reqFast) begin
                            if (isRemOp(reqOp))
                                resultReg <= reqDivZero ? i_reqA : '0;
                            else
                                resultReg <= reqDivZero ? '1 : i_reqA;
                        end else begin
                            aReg   <= absA;
                            bReg   <= absB;
                            remReg <= '0;
                            cnt    <= CNT_WIDTH'(W - 1);
                            negQ   <= reqSigned &&
                                      (i_reqA[W-1] ^ i_reqB[W-1]);
                            negR   <= reqSigned && i_reqA[W-1];
                        end
                    end
                end
                MUL: begin
                    if (opReg == OP_MUL) resultReg <= product[W-1:0];
                    else                 resultReg <= product[2*W-1:W];
                end
                DIV: begin
                    aReg   <= stepQuo;
                    remReg <= stepRem;
                    if (cnt == '0)
                        resultReg <= isRemOp(opReg) ? fixRem : fixQuo;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
